bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Multi-digit packed-BCD down counter: the decrementing counterpart of the team's single-digit BCD incrementor.
- Chains per-digit decrement/borrow logic across DIGITS nibbles behind a register bank.
- Provides load, decrement-enable, underflow/wrap control and terminal-count flags.
- Used for countdown timers and display-driven down-counters in the datapath.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS bits, digit 0 in bits [3:0] (least significant).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  load load_val into count this cycle
load_val  input  4*DIGITS  packed-BCD value to load
dec  input  1  decrement count by one this cycle
wrap_en  input  1  1: decrement from zero wraps to all-9s; 0: holds at zero
count  output  4*DIGITS  current packed-BCD count (registered)
zero  output  1  high while count == 0 (decoded from count register)
done  output  1  one-cycle pulse: count reached 0 via decrement
borrow  output  1  one-cycle pulse: decrement at zero with wrap_en=1
load_err  output  1  one-cycle pulse: load rejected, some load_val digit > 9

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
  - Reset values: count=0, done=0, borrow=0, load_err=0; zero=1 (follows count).
- Priority, evaluated each rising edge: reset > load > dec > hold.
- Load:
  - If every load_val digit is <= 9, count <= load_val next cycle (latency 1) and load_err stays 0.
  - If any digit is > 9, count is unchanged and load_err=1 for one cycle.
  - A concurrent dec is ignored in both cases.
  - done and borrow stay 0 on any load cycle, including loading 0.
- Decrement (dec=1, load=0):
  - Digit 0 always receives a borrow-in.
  - Per digit with borrow-in: digit==0 -> 9 with borrow-out=1; else digit-1 with borrow-out=0.
  - Digits without borrow-in are unchanged.
  - Borrow ripples within the same cycle; latency is 1 cycle.
- Terminal and boundary cases:
  - count==1 with dec -> count=0, done=1 for one cycle.
  - count==0 with dec and wrap_en=1 -> count=all-9s (e.g. 9999 for DIGITS=4), borrow=1 for one cycle, done=0.
  - count==0 with dec and wrap_en=0 -> count holds 0; done=0, borrow=0.
- Pulse outputs:
  - done, borrow and load_err are registered, asserted only in the cycle after the triggering edge, and otherwise 0.
  - Back-to-back events each produce their own pulse.
- zero is combinational from the count register only, with no input-to-output path.
- dec=0 and load=0: all state holds; pulse outputs return to 0.
- Reset mid-sequence clears any pending pulse outputs on the same edge.
- count always holds valid BCD; no illegal digit is ever produced.

Test Plan:
- Reset: assert reset with count=0375 -> next cycle count=0000, zero=1, done=borrow=load_err=0.
- Load and priority: load=1, load_val=1000, dec=1 -> count=1000; then dec for one cycle -> count=0999 (3-digit borrow ripple), no pulses.
- Countdown to zero: load 0003, dec held 3 cycles -> 0002, 0001, 0000; done=1 only in the final cycle; zero=1 from then on.
- Underflow with wrap: count=0000, wrap_en=1, dec=1 -> count=9999, borrow=1 one cycle; repeat with wrap_en=0 -> count stays 0000, borrow=0, done=0.
- Invalid load: count=0042, load_val=12A4 -> count stays 0042, load_err=1 one cycle; then load 0042 -> load_err=0.
- Random dec/load mix: 2000 cycles against a decimal reference model -> count matches, all digits <= 9, pulses match the model's events.

Source files
------------

// File: rtl/bcd_down_counter.sv
// Multi-digit packed-BCD down counter with load, wrap/hold at zero,
// and registered single-cycle pulses for done, borrow and rejected loads.
module bcd_down_counter #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                dec,
    input  logic                wrap_en,
    output logic [4*DIGITS-1:0] count,
    output logic                zero,
    output logic                done,
    output logic                borrow,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] dec_val;
    logic         load_bad;
    logic         count_is_one;
    logic         bin;
    logic [3:0]   dig;

    // Borrow ripples from digit 0 upward; digits above the last borrow pass through.
    always_comb begin
        dec_val = count;
        bin     = 1'b1;
        dig     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count[4*i +: 4];
            if (bin) begin
                if (dig == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                    bin               = 1'b1;
                end else begin
                    dec_val[4*i +: 4] = dig - 4'd1;
                    bin               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end
        end
    end

    assign count_is_one = (count == W'(1));
    assign zero         = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            done     <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_bad) begin
                    load_err <= 1'b1;
                end else begin
                    count <= load_val;
                end
            end else if (dec) begin
                if (zero) begin
                    // From zero the ripple already yields all-9s; only wrap_en gates it.
                    if (wrap_en) begin
                        count  <= dec_val;
                        borrow <= 1'b1;
                    end
                end else begin
                    count <= dec_val;
                    done  <= count_is_one;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: directed boundary steps followed by a random
// load/dec mix, checked against an integer decimal model of the count.
module tb_bcd_down_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAX_V  = 9999;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         dec = 1'b0;
    logic         wrap_en = 1'b0;
    logic [W-1:0] count;
    logic         zero;
    logic         done;
    logic         borrow;
    logic         load_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain decimal value plus expected pulses.
    int   m_val = 0;
    logic m_done = 1'b0;
    logic m_borrow = 1'b0;
    logic m_lerr = 1'b0;
    logic [W-1:0] exp_q[$];

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .wrap_en  (wrap_en),
        .count    (count),
        .zero     (zero),
        .done     (done),
        .borrow   (borrow),
        .load_err (load_err)
    );

    // Clock/reset block
    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] b);
        for (int i = 0; i < DIGITS; i++)
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int v;
        v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model update from the inputs presented at this edge.
    task automatic model_step();
        m_done   = 1'b0;
        m_borrow = 1'b0;
        m_lerr   = 1'b0;
        if (reset) begin
            m_val = 0;
        end else if (load) begin
            if (is_bcd(load_val)) m_val = from_bcd(load_val);
            else m_lerr = 1'b1;
        end else if (dec) begin
            if (m_val == 0) begin
                if (wrap_en) begin
                    m_val    = MAX_V;
                    m_borrow = 1'b1;
                end
            end else begin
                m_val  = m_val - 1;
                m_done = (m_val == 0);
            end
        end
        exp_q.push_back(to_bcd(m_val));
    endtask

    // Driver: present inputs, clock once, compare all outputs #1 after the edge.
    task automatic step(input logic r, input logic ld, input logic [W-1:0] lv,
                        input logic d, input logic we, input string tag);
        logic [W-1:0] exp_count;
        reset    = r;
        load     = ld;
        load_val = lv;
        dec      = d;
        wrap_en  = we;
        @(posedge clk);
        model_step();
        #1;
        exp_count = exp_q.pop_front();
        check({tag, ".count"},    count,          exp_count);
        check({tag, ".zero"},     W'(zero),       W'(m_val == 0));
        check({tag, ".done"},     W'(done),       W'(m_done));
        check({tag, ".borrow"},   W'(borrow),     W'(m_borrow));
        check({tag, ".load_err"}, W'(load_err),   W'(m_lerr));
        check({tag, ".bcd_ok"},   W'(is_bcd(count)), W'(1'b1));
    endtask

    initial begin
        logic [W-1:0] lv;
        int r;

        step(1'b1, 1'b0, '0, 1'b0, 1'b0, "init_reset");

        // Reset from a nonzero count, with dec also requested
        step(1'b0, 1'b1, 16'h0375, 1'b0, 1'b0, "load_0375");
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, "reset_0375");
        check("reset_count_const", count, 16'h0000);

        // Load beats dec, then multi-digit borrow ripple
        step(1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, "load_prio");
        check("load_prio_const", count, 16'h1000);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, "ripple");
        check("ripple_const", count, 16'h0999);

        // Countdown to zero
        step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, "load_3");
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, "cd_2");
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, "cd_1");
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, "cd_0");
        check("cd_done_const", W'(done), W'(1'b1));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, "cd_hold");

        // Underflow with and without wrap
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, "wrap");
        check("wrap_const", count, 16'h9999);
        check("wrap_borrow_const", W'(borrow), W'(1'b1));
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "load_0");
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, "nowrap");
        check("nowrap_const", count, 16'h0000);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, "wrap_b2b_a");
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, "wrap_b2b_ld");
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, "wrap_b2b_b");

        // Invalid load keeps count, valid one clears load_err
        step(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, "load_42");
        step(1'b0, 1'b1, 16'h12A4, 1'b1, 1'b0, "bad_load");
        check("bad_load_const", count, 16'h0042);
        check("bad_load_err_const", W'(load_err), W'(1'b1));
        step(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, "good_load");

        // Random mix, biased toward small loads so zero is crossed often
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                step(1'b1, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rnd_reset");
            end else if (r < 8) begin
                case ($urandom_range(0, 2))
                    0:       lv = to_bcd($urandom_range(0, 5));
                    1:       lv = to_bcd($urandom_range(0, MAX_V));
                    default: lv = W'($urandom);
                endcase
                step(1'b0, 1'b1, lv, 1'($urandom), 1'($urandom), "rnd_load");
            end else if (r < 80) begin
                step(1'b0, 1'b0, W'($urandom), 1'b1, 1'($urandom), "rnd_dec");
            end else begin
                step(1'b0, 1'b0, W'($urandom), 1'b0, 1'($urandom), "rnd_hold");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
